// File: rtl/sram_burst_controller_if.sv
// CPU-side memory-stage bus of the SRAM burst controller: request, write line, read line,
// pipeline-freeze handshake and address-error pulse.
interface sram_burst_controller_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RD_BEATS = 4,
    parameter int unsigned WR_BEATS = 2
);
    logic                         Write_En;
    logic                         Read_En;
    logic [31:0]                  address;
    logic [WR_BEATS*DATA_W-1:0]   writeData;
    logic [RD_BEATS*DATA_W-1:0]   readData;
    logic                         ready;
    logic                         err;

    modport master (
        output Write_En, Read_En, address, writeData,
        input  readData, ready, err
    );

    modport slave (
        input  Write_En, Read_En, address, writeData,
        output readData, ready, err
    );
endinterface

// File: rtl/sram_burst_controller.sv
// Burst SRAM controller: cache-line read bursts and short write bursts over an async SRAM,
// with per-beat wait states, base-address rebasing and an address-range error pulse.
module sram_burst_controller #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned RD_BEATS    = 4,
    parameter int unsigned WR_BEATS    = 2,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_burst_controller_if.slave     cpu,
    inout  wire  [DATA_W-1:0]          SRAM_DQ,
    output logic [ADDR_W-1:0]          SRAM_ADDR,
    output logic                       SRAM_UB_N,
    output logic                       SRAM_LB_N,
    output logic                       SRAM_WE_N,
    output logic                       SRAM_CE_N,
    output logic                       SRAM_OE_N
);
    localparam int unsigned B         = DATA_W / 8;
    localparam int unsigned BEAT_W    = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;
    localparam int unsigned WAIT_W    = 4;
    localparam int unsigned RD_LINE_W = RD_BEATS * DATA_W;
    localparam int unsigned WR_LINE_W = WR_BEATS * DATA_W;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   op_wr_q, op_wr_d;
    logic                   err_flag_q, err_flag_d;
    logic [WR_LINE_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [RD_LINE_W-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   we_n_q, we_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   dq_oe_q, dq_oe_d;
    logic [DATA_W-1:0]      dq_out_q, dq_out_d;

    // Request decode: rebased offset, aligned burst base and range check for both op types
    logic [31:0] offset, rd_base, wr_base;
    logic [32:0] rd_last, wr_last;
    logic        below_base, rd_range_err, wr_range_err;

    assign offset       = cpu.address - 32'(BASE_ADDR);
    assign below_base   = cpu.address < 32'(BASE_ADDR);
    assign rd_base      = (offset / 32'(RD_BEATS * B)) * 32'(RD_BEATS);
    assign wr_base      = (offset / 32'(WR_BEATS * B)) * 32'(WR_BEATS);
    assign rd_last      = {1'b0, rd_base} + 33'(RD_BEATS - 1);
    assign wr_last      = {1'b0, wr_base} + 33'(WR_BEATS - 1);
    assign rd_range_err = (rd_last >> ADDR_W) != 33'd0;
    assign wr_range_err = (wr_last >> ADDR_W) != 33'd0;

    logic              wait_done, drive_wr;
    logic [BEAT_W-1:0] beat_last;

    assign wait_done = wait_q == WAIT_W'(WAIT_CYCLES);
    assign beat_last = op_wr_q ? BEAT_W'(WR_BEATS - 1) : BEAT_W'(RD_BEATS - 1);

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        wait_d     = wait_q;
        op_wr_d    = op_wr_q;
        err_flag_d = err_flag_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        drive_wr   = 1'b0;
        dq_out_d   = '0;

        case (state_q)
            IDLE: begin
                if (cpu.Write_En || cpu.Read_En) begin
                    op_wr_d = cpu.Write_En;
                    wdata_d = cpu.writeData;
                    beat_d  = '0;
                    wait_d  = '0;
                    if (below_base || (cpu.Write_En ? wr_range_err : rd_range_err)) begin
                        err_flag_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        err_flag_d = 1'b0;
                        state_d    = ACCESS;
                        addr_d     = cpu.Write_En ? ADDR_W'(wr_base) : ADDR_W'(rd_base);
                    end
                end
            end
            ACCESS: begin
                if (wait_done) begin
                    // Read data is sampled on the last cycle of the beat, after the wait states
                    if (!op_wr_q) begin
                        for (int i = 0; i < int'(RD_BEATS); i++) begin
                            if (beat_q == BEAT_W'(i)) rdata_d[i*DATA_W +: DATA_W] = SRAM_DQ;
                        end
                    end
                    wait_d = '0;
                    if (beat_q == beat_last) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        // Bus drivers follow the next state so they are registered in step with SRAM_ADDR
        drive_wr = (state_d == ACCESS) && op_wr_d;
        for (int i = 0; i < int'(WR_BEATS); i++) begin
            if (beat_d == BEAT_W'(i)) dq_out_d = wdata_d[i*DATA_W +: DATA_W];
        end
        we_n_d  = !drive_wr;
        oe_n_d  = drive_wr;
        dq_oe_d = drive_wr;
        err_d   = (state_d == DONE) && err_flag_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            wait_q     <= '0;
            op_wr_q    <= 1'b0;
            err_flag_q <= 1'b0;
            wdata_q    <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b0;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            wait_q     <= wait_d;
            op_wr_q    <= op_wr_d;
            err_flag_q <= err_flag_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            dq_oe_q    <= dq_oe_d;
            dq_out_q   <= dq_out_d;
        end
    end

    // Freeze the pipeline whenever a request is pending or a burst is in flight
    assign cpu.ready    = (state_q == DONE) ||
                          ((state_q == IDLE) && !(cpu.Write_En || cpu.Read_En));
    assign cpu.err      = err_q;
    assign cpu.readData = rdata_q;

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
endmodule

// File: tb/tb_sram_burst_controller.sv
// Directed bench for sram_burst_controller: default instance plus a one-wait-state instance,
// each with a small behavioural SRAM on its data bus.
module tb_sram_burst_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    sram_burst_controller_if #(.DATA_W(16), .RD_BEATS(4), .WR_BEATS(2)) bus0 ();
    sram_burst_controller_if #(.DATA_W(16), .RD_BEATS(4), .WR_BEATS(2)) bus1 ();

    wire  [15:0] dq0, dq1;
    logic [17:0] addr0, addr1;
    logic        ub0, lb0, we0, ce0, oe0;
    logic        ub1, lb1, we1, ce1, oe1;

    sram_burst_controller u0 (
        .clk(clk), .rst(rst), .cpu(bus0.slave), .SRAM_DQ(dq0), .SRAM_ADDR(addr0),
        .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_WE_N(we0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
    );

    sram_burst_controller #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .cpu(bus1.slave), .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_WE_N(we1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
    );

    // Memory 0: word i holds A000+i until written; with mem_on low it drives 0 so a
    // controller still driving the bus shows up as a wrong value.
    logic [15:0] mem0 [256];
    logic        mem_on;
    assign dq0 = (!oe0 && we0) ? (mem_on ? mem0[addr0[7:0]] : 16'h0000) : 16'hzzzz;

    always @(posedge clk) begin
        if (rst && !mem_on) begin
        end else if (rst) begin
            for (int i = 0; i < 256; i++) mem0[i] <= 16'hA000 + 16'(i);
        end else if (!we0) begin
            mem0[addr0[7:0]] <= dq0;
        end
    end

    // Memory 1: word i reads B000+i, but only once the address has been stable for a cycle
    logic [17:0] prev1 = '0;
    always @(posedge clk) prev1 <= addr1;
    assign dq1 = (!oe1 && we1) ? ((addr1 == prev1) ? (16'hB000 | {8'h00, addr1[7:0]}) : 16'hBAD0)
                               : 16'hzzzz;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        mem_on = 1'b1;
        bus0.Write_En = 1'b0; bus0.Read_En = 1'b0; bus0.address = '0; bus0.writeData = '0;
        bus1.Write_En = 1'b0; bus1.Read_En = 1'b0; bus1.address = '0; bus1.writeData = '0;
        repeat (3) next_cycle();

        check("rst_readData", 64'(bus0.readData), 64'h0);
        check("rst_err", 64'(bus0.err), 64'h0);
        check("rst_addr", 64'(addr0), 64'h0);
        check("rst_we_n", 64'(we0), 64'h1);
        check("rst_oe_n", 64'(oe0), 64'h0);
        check("rst_ready", 64'(bus0.ready), 64'h1);
        check("tieoffs", 64'({ce0, ub0, lb0}), 64'h0);
        rst = 1'b0;
        next_cycle();

        // Default read burst at 1032 -> words 4..7
        bus0.Read_En = 1'b1; bus0.address = 32'd1032;
        #1 check("rd_ready_c0", 64'(bus0.ready), 64'h0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            check("rd_addr", 64'(addr0), 64'(3 + k));
            check("rd_we_n", 64'(we0), 64'h1);
            check("rd_ready_busy", 64'(bus0.ready), 64'h0);
        end
        next_cycle();
        check("rd_ready_c5", 64'(bus0.ready), 64'h1);
        check("rd_err_c5", 64'(bus0.err), 64'h0);
        check("rd_line", 64'(bus0.readData), 64'hA007_A006_A005_A004);
        bus0.Read_En = 1'b0;
        next_cycle();

        // Write burst at 1028 -> words 2,3
        mem_on = 1'b0;
        bus0.Write_En = 1'b1; bus0.address = 32'd1028; bus0.writeData = 32'hDEADBEEF;
        next_cycle();
        check("wr_addr_c1", 64'(addr0), 64'd2);
        check("wr_dq_c1", 64'(dq0), 64'hBEEF);
        check("wr_we_n_c1", 64'(we0), 64'h0);
        check("wr_oe_n_c1", 64'(oe0), 64'h1);
        next_cycle();
        check("wr_addr_c2", 64'(addr0), 64'd3);
        check("wr_dq_c2", 64'(dq0), 64'hDEAD);
        check("wr_we_n_c2", 64'(we0), 64'h0);
        next_cycle();
        check("wr_ready_c3", 64'(bus0.ready), 64'h1);
        check("wr_we_n_c3", 64'(we0), 64'h1);
        check("wr_dq_released", 64'(dq0), 64'h0);
        check("wr_keeps_line", 64'(bus0.readData), 64'hA007_A006_A005_A004);
        bus0.Write_En = 1'b0;
        next_cycle();
        mem_on = 1'b1;

        // Read back line 0 including the written words
        bus0.Read_En = 1'b1; bus0.address = 32'd1024;
        repeat (4) next_cycle();
        check("rb_ready_c4", 64'(bus0.ready), 64'h0);
        next_cycle();
        check("rb_ready_c5", 64'(bus0.ready), 64'h1);
        check("rb_line", 64'(bus0.readData), 64'hDEAD_BEEF_A001_A000);
        bus0.Read_En = 1'b0;
        next_cycle();

        // Both enables: write wins, line untouched
        mem_on = 1'b0;
        bus0.Read_En = 1'b1; bus0.Write_En = 1'b1; bus0.address = 32'd1028;
        bus0.writeData = 32'h12345678;
        next_cycle();
        check("both_we_n_c1", 64'(we0), 64'h0);
        check("both_addr_c1", 64'(addr0), 64'd2);
        check("both_dq_c1", 64'(dq0), 64'h5678);
        next_cycle();
        check("both_we_n_c2", 64'(we0), 64'h0);
        check("both_dq_c2", 64'(dq0), 64'h1234);
        next_cycle();
        check("both_ready_c3", 64'(bus0.ready), 64'h1);
        check("both_line", 64'(bus0.readData), 64'hDEAD_BEEF_A001_A000);
        bus0.Read_En = 1'b0; bus0.Write_En = 1'b0;
        next_cycle();
        mem_on = 1'b1;

        // Below base address
        bus0.Read_En = 1'b1; bus0.address = 32'd1000;
        next_cycle();
        check("lo_ready_c1", 64'(bus0.ready), 64'h1);
        check("lo_err_c1", 64'(bus0.err), 64'h1);
        check("lo_we_n", 64'(we0), 64'h1);
        check("lo_addr", 64'(addr0), 64'd3);
        bus0.Read_En = 1'b0;
        next_cycle();
        check("lo_err_c2", 64'(bus0.err), 64'h0);

        // Just past the top of SRAM
        bus0.Read_En = 1'b1; bus0.address = 32'd525312;
        next_cycle();
        check("hi_err_c1", 64'(bus0.err), 64'h1);
        check("hi_addr", 64'(addr0), 64'd3);
        bus0.Read_En = 1'b0;
        next_cycle();

        // Last legal line
        bus0.Read_En = 1'b1; bus0.address = 32'd525304;
        next_cycle();
        check("top_addr_c1", 64'(addr0), 64'h3FFFC);
        check("top_ready_c1", 64'(bus0.ready), 64'h0);
        repeat (3) next_cycle();
        next_cycle();
        check("top_ready_c5", 64'(bus0.ready), 64'h1);
        check("top_err_c5", 64'(bus0.err), 64'h0);
        check("top_line", 64'(bus0.readData), 64'hA0FF_A0FE_A0FD_A0FC);
        bus0.Read_En = 1'b0;
        next_cycle();

        // One wait state: each address held two cycles, sample on the second
        bus1.Read_En = 1'b1; bus1.address = 32'd1024;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            check("ws_addr", 64'(addr1), 64'((k - 1) / 2));
            check("ws_ready_busy", 64'(bus1.ready), 64'h0);
        end
        next_cycle();
        check("ws_ready_c9", 64'(bus1.ready), 64'h1);
        check("ws_line", 64'(bus1.readData), 64'hB003_B002_B001_B000);
        bus1.Read_En = 1'b0;
        next_cycle();

        // Reset in the middle of a write burst
        mem_on = 1'b0;
        bus0.Write_En = 1'b1; bus0.address = 32'd1028; bus0.writeData = 32'hCAFEF00D;
        next_cycle();
        check("ab_we_n_c1", 64'(we0), 64'h0);
        next_cycle();
        check("ab_we_n_c2", 64'(we0), 64'h0);
        rst = 1'b1; bus0.Write_En = 1'b0;
        next_cycle();
        check("ab_we_n", 64'(we0), 64'h1);
        check("ab_dq_released", 64'(dq0), 64'h0);
        check("ab_readData", 64'(bus0.readData), 64'h0);
        check("ab_addr", 64'(addr0), 64'h0);
        check("ab_ready_idle", 64'(bus0.ready), 64'h1);
        rst = 1'b0;
        bus0.Read_En = 1'b1; bus0.address = 32'd1024;
        #1 check("ab_ready_req", 64'(bus0.ready), 64'h0);
        mem_on = 1'b1;
        bus0.Read_En = 1'b0;
        repeat (6) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
